// File: rtl/rect_draw_pkg.sv
// rtl/rect_draw_pkg.sv - shared constants and state encoding for rect_draw_engine
package rect_draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/rect_draw_engine_if.sv
// rtl/rect_draw_engine_if.sv - request handshake and pixel bus between controller and rect_draw_engine
interface rect_draw_engine_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] colour;
    logic                fill;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOUR_W-1:0] colour_out;
    logic                plot;

    modport master (
        output start, x0, y0, w, h, colour, fill,
        input  busy, done, x_out, y_out, colour_out, plot
    );

    modport slave (
        input  start, x0, y0, w, h, colour, fill,
        output busy, done, x_out, y_out, colour_out, plot
    );
endinterface

// File: rtl/rect_scan_counter.sv
// rtl/rect_scan_counter.sv - row-major dx/dy sweep counter with end-of-rectangle flag
module rect_scan_counter #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           en,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] dx,
    output logic [Y_W-1:0] dy,
    output logic           last
);

    logic row_end;

    assign row_end = (dx == w - X_W'(1));
    assign last    = row_end && (dy == h - Y_W'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            dx <= '0;
            dy <= '0;
        end else if (clear) begin
            dx <= '0;
            dy <= '0;
        end else if (en) begin
            if (row_end) begin
                dx <= '0;
                dy <= dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rect_draw_engine.sv
// rtl/rect_draw_engine.sv - one-pixel-per-clock rectangle sweep feeding the VGA adapter
// Optional off-screen clipping enabled by defining RECT_DRAW_CLIP_EN.
module rect_draw_engine
    import rect_draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    rect_draw_engine_if.slave bus
);

    state_t state, state_next;

    logic [X_W-1:0]      x0_l;
    logic [Y_W-1:0]      y0_l;
    logic [X_W-1:0]      w_l;
    logic [Y_W-1:0]      h_l;
    logic [COLOUR_W-1:0] colour_l;
    logic                fill_l;

    logic           cnt_clear;
    logic           cnt_en;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    logic           last;
    logic           accept;

    rect_scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_scan (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .w     (w_l),
        .h     (h_l),
        .dx    (dx),
        .dy    (dy),
        .last  (last)
    );

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    cnt_clear = 1'b1;
                    state_next = (bus.w == '0 || bus.h == '0) ? DONE : DRAW;
                end
            end
            DRAW: begin
                cnt_en = 1'b1;
                if (last) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x0_l     <= '0;
            y0_l     <= '0;
            w_l      <= '0;
            h_l      <= '0;
            colour_l <= '0;
            fill_l   <= 1'b0;
        end else if (accept) begin
            x0_l     <= bus.x0;
            y0_l     <= bus.y0;
            w_l      <= bus.w;
            h_l      <= bus.h;
            colour_l <= bus.colour;
            fill_l   <= bus.fill;
        end
    end

    logic [X_W-1:0] x_pix;
    logic [Y_W-1:0] y_pix;
    logic           on_edge;
    logic           on_screen;

    assign on_edge = fill_l || (dx == '0) || (dx == w_l - X_W'(1))
                     || (dy == '0) || (dy == h_l - Y_W'(1));

`ifdef RECT_DRAW_CLIP_EN
    // Full-width sums so pixels past the screen edge are detected rather than wrapped.
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;
    assign x_sum     = {1'b0, x0_l} + {1'b0, dx};
    assign y_sum     = {1'b0, y0_l} + {1'b0, dy};
    assign x_pix     = x_sum[X_W-1:0];
    assign y_pix     = y_sum[Y_W-1:0];
    assign on_screen = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
`else
    assign x_pix     = x0_l + dx;
    assign y_pix     = y0_l + dy;
    assign on_screen = 1'b1;
`endif

    // Outputs are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.plot       <= 1'b0;
            bus.x_out      <= '0;
            bus.y_out      <= '0;
            bus.colour_out <= '0;
        end else begin
            bus.busy <= (state != IDLE);
            bus.done <= (state == DONE);
            bus.plot <= 1'b0;
            if (state == DRAW) begin
                bus.plot       <= on_edge && on_screen;
                bus.x_out      <= x_pix;
                bus.y_out      <= y_pix;
                bus.colour_out <= colour_l;
            end
        end
    end

endmodule
